// File: rtl/serial_addsub_moore.sv
// LSB-first serial adder/subtractor, Moore style: the result bit and carry are held in
// the state register, and the word is framed by start/in_valid with abort on a mid-word start.
module serial_addsub_moore #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             start,
  input  logic             sub,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             sum_valid,
  output logic             done,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] word_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  // Encoding is {busy, S, C}, so sum and the carry are plain register bits.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    S0C0 = 3'b100,
    S0C1 = 3'b101,
    S1C0 = 3'b110,
    S1C1 = 3'b111
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       state_bits;
  logic [CW-1:0]    cnt_q;
  logic             open_q;
  logic             mode_q, mode_d;
  logic             sum_valid_q, done_q, carry_out_q, overflow_q;
  logic [WIDTH-1:0] asm_q, asm_d, word_q;

  logic start_beat, beat, last;
  logic cin, bb, s, cout, ovf;

  assign state_bits = state_q;

  always_comb begin
    start_beat = in_valid & start;
    beat       = start_beat | (in_valid & open_q);
    last       = in_valid & ~start & open_q & (cnt_q == CW'(WIDTH - 1));
    mode_d     = start_beat ? sub : mode_q;
    // An aborting start must not inherit the old carry.
    cin        = start_beat ? sub : state_bits[0];
    bb         = b ^ mode_d;
    s          = a ^ bb ^ cin;
    cout       = (a & bb) | (a & cin) | (bb & cin);
    ovf        = SIGNED ? (cin ^ cout) : (cout ^ mode_d);
    asm_d      = {s, asm_q[WIDTH-1:1]};
    state_d    = state_q;
    if (beat) begin
      unique case ({s, cout})
        2'b00:   state_d = S0C0;
        2'b01:   state_d = S0C1;
        2'b10:   state_d = S1C0;
        default: state_d = S1C1;
      endcase
    end else if (!open_q && !start_beat) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      mode_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      asm_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      sum_valid_q <= beat;
      done_q      <= last;
      if (beat) begin
        mode_q <= mode_d;
        asm_q  <= asm_d;
      end
      if (start_beat) begin
        cnt_q  <= CW'(1);
        open_q <= 1'b1;
      end else if (last) begin
        cnt_q       <= '0;
        open_q      <= 1'b0;
        carry_out_q <= cout;
        overflow_q  <= ovf;
        word_q      <= asm_d;
      end else if (beat) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign sum       = state_bits[1];
  assign sum_valid = sum_valid_q;
  assign done      = done_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign word_out  = word_q;

endmodule

// File: doc/serial_addsub_moore.md
# serial_addsub_moore

Parametrised, word-framed, LSB-first serial adder/subtractor built as a Moore machine. It is the successor to the fixed 1-bit serial adder FSM and adds configurable word length, per-word add/subtract mode, an input-valid stall, word framing with abort, and end-of-word flags. It also assembles a parallel result word. It sits between serial bit-stream sources and the word-level datapath.

## Interface
- `WIDTH`, default 8: bits per word, legal range 2..32.
- `SIGNED`, default 0: 1 means overflow is two's-complement overflow; 0 means unsigned carry/borrow.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `a`/`b` carry a bit this cycle.
- `start`  in  1  qualifies the current bit as bit 0 of a new word; ignored unless `in_valid`=1.
- `sub`  in  1  mode, sampled only on start beats: 0 adds, 1 computes a−b.
- `a`, `b`  in  1  operand bits, LSB first.
- `sum`  out  1  registered result bit.
- `sum_valid`  out  1  `sum` is meaningful this cycle.
- `done`  out  1  one-cycle pulse coinciding with the MSB result.
- `carry_out`  out  1  final carry of the word; for subtract, 1 means no borrow. Held until the next `done`.
- `overflow`  out  1  see Operation. Held until the next `done`.
- `word_out`  out  WIDTH  assembled result. Held until the next `done`.

## Operation
- State machine has five states: IDLE, S0C0, S1C0, S0C1, S1C1. `sum` is the S bit of the state and is 0 in IDLE. The C bit is the carry into the next bit.
- Effective operand: b' = b ^ mode. Carry-in for bit 0 = mode.
- On each accepted beat (`in_valid`=1 with a word open, or a start beat):
  - s = a ^ b' ^ cin
  - cout = maj(a, b', cin)
  - next state = S{s}C{cout}
- A bit counter (0..WIDTH−1) tracks position in the word.
- Word open: entered on a start beat; closes after WIDTH accepted beats.
- `in_valid`=1 with `start`=0 while no word is open: the bit is discarded, the state is unchanged and `sum_valid` is 0.
- `in_valid`=0: the state, counter and carry hold. `sum_valid` goes to 0 in the following cycle (stall).
- `start`=1 mid-word (abort):
  - The current word is discarded; no `done` is produced and the held flags are unchanged.
  - The beat is processed as bit 0 of a new word with a freshly sampled `sub`. Carry-in is `sub`; the old carry is not used.
- End of word: on the WIDTH-th beat, the registered outputs in the next cycle are:
  - `done`=1.
  - `carry_out` = cout of the MSB.
  - `overflow`:
    - `SIGNED`=1: cin(MSB) ^ cout(MSB).
    - `SIGNED`=0: cout when adding, ~cout when subtracting.
  - `word_out` = shift-assembled result bits.
- After a word closes, the state remains the last S/C state. It returns to IDLE only when the next cycle is not a start beat.
- Back-to-back words: a start beat on the cycle immediately after the MSB beat is accepted with no bubble.
- Reset: all outputs are 0, the state is IDLE, the counter is 0 and `word_out` is 0. Reset asserted mid-word discards the word. The first start beat after reset release works normally.

## Timing
- Latency: bit k accepted at edge n appears on `sum` with `sum_valid`=1 after edge n, i.e. during cycle n+1.
- `done`, `carry_out`, `overflow` and `word_out` update in the same cycle as the MSB result bit.
- Throughput: 1 bit per clock; one word per WIDTH clocks when unstalled.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.
- Asynchronous reset takes effect without a clock edge. Release is synchronous to `clk` by the system.

## Test plan
- WIDTH=4, SIGNED=1, add 3+5: a=1,1,0,0 and b=1,0,1,0 with start on the first beat.
  - Required: `sum` stream 0,0,0,1.
  - Required: `word_out`=1000, `carry_out`=0, `overflow`=1, `done` with the 4th `sum_valid`.
- WIDTH=4, SIGNED=1, sub=1, 5−3.
  - Required: `word_out`=0010, `carry_out`=1, `overflow`=0.
- WIDTH=4, SIGNED=0, sub=1, 3−5 immediately back-to-back after the previous word.
  - Required: `word_out`=1110, `carry_out`=0, `overflow`=1.
  - Required: no idle cycle between the two `done` pulses except the 3 intervening cycles.
- Stall: `in_valid`=0 for 2 cycles after bit 1 of 3+5.
  - Required: `sum_valid`=0 in exactly those 2 cycles.
  - Required: same result as the first scenario; `done` is delayed by 2 cycles.
- Abort: start re-asserted at bit 2 of a word, followed by a full 7+1 add.
  - Required: no `done` for the aborted word.
  - Required: `word_out`=1000, `carry_out`=0, `overflow`=1.
- Reset mid-word (`rst` low during bit 1).
  - Required: all outputs are 0 immediately.
  - Required: a subsequent 2+2 gives `word_out`=0100 with `carry_out`=0.
